// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//
// Elastic pipeline stage with a valid/ready handshake and a one-entry skid
// buffer. It sustains one beat per cycle under back-pressure, and in_ready
// depends only on registered state. There is no combinational path from
// out_ready to in_ready, or from in_valid to out_valid. On a bubble the
// control field is zeroed, so a stale reg_write can never fire. The payload
// is only held on a bubble; reset is the one thing that clears it.
//
// Optional feature (macro PIPE_STAGE_STALL_CNT_EN):
//   When defined, adds parameter CNT_W and output stall_cnt. stall_cnt is a
//   saturating count of the cycles with out_valid=1 and out_ready=0. Only
//   rst clears it; flush does not.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   flush      in   synchronous flush, drops every held beat
//   in_valid   in   upstream beat valid
//   in_ready   out  stage can accept (= skid empty)
//   in_ctrl    in   upstream control field   [CTRL_W]
//   in_data    in   upstream payload         [DATA_W]
//   out_valid  out  downstream beat valid
//   out_ready  in   downstream accepts
//   out_ctrl   out  held control, zero when out_valid=0 [CTRL_W]
//   out_data   out  held payload            [DATA_W]
//   stall_cnt  out  back-pressure cycle count [CNT_W] (feature only)
//
// State (encoded by {main_valid_q, skid_valid_q}):
//   state    | meaning
//   ST_EMPTY | nothing held, main and skid both bubbles
//   ST_ONE   | one beat in main, driving the outputs
//   ST_FULL  | beat in main plus a younger beat parked in skid
//   ST_BAD   | skid without main; unreachable, recovers to empty
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 101
`ifdef PIPE_STAGE_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BAD   = 2'b01,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  state_t state;
  logic   acc;
  logic   take;

  assign state     = state_t'({main_valid_q, skid_valid_q});
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

  assign acc  = in_valid & in_ready;
  assign take = main_valid_q & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      // Any take in this cycle has already been delivered. Whatever is
      // presented upstream is discarded. Payloads stay; only control is
      // zeroed.
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (acc) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = in_ctrl;
            main_data_d  = in_data;
          end
        end
        ST_ONE: begin
          if (acc && take) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
          end else if (take) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so acc cannot happen.
          if (take) begin
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
          end
        end
        default: begin
          skid_valid_d = 1'b0;
          skid_ctrl_d  = '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;
  localparam int CW = 3;
  localparam int DW = 101;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;
  beat_t sb_q[$];

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [3:0] stall_cnt;
  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt));
`else
  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data));
`endif

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d);
    beat_t b;
    b.ctrl = c;
    b.data = d;
    sb_q.push_back(b);
  endtask

  // Downstream monitor: every take must match the oldest expected beat,
  // and every bubble cycle must show zero control.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        assert (sb_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_beat: observed ctrl %0h data %0h expected none", out_ctrl, out_data);
        end
        if (sb_q.size() != 0) begin
          beat_t e;
          e = sb_q.pop_front();
          chk("take_ctrl", 128'(out_ctrl), 128'(e.ctrl));
          chk("take_data", 128'(out_data), 128'(e.data));
        end
      end
      if (!out_valid) chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_ctrl",  128'(out_ctrl),  128'(0));
    chk("rst_out_data",  128'(out_data),  128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(1));
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));
`endif
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Streaming: 8 back-to-back beats, 1-cycle latency.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("stream_in_ready", 128'(in_ready), 128'(1));
      drive(1'b1, 3'b101, DW'(i));
      push(3'b101, DW'(i));
      cyc();
      chk("stream_out_valid", 128'(out_valid), 128'(1));
      chk("stream_latency",   128'(out_data),  128'(i));
    end
    drive(1'b0, '0, '0);
    cyc(); cyc();
    chk("stream_drained", 128'(sb_q.size()), 128'(0));

    // Back-pressure: A in main, B in skid, C held upstream.
    out_ready = 1'b0;
    drive(1'b1, 3'b001, DW'('h11)); push(3'b001, DW'('h11));
    cyc();
    chk("bp_ready_after_a", 128'(in_ready), 128'(1));
    drive(1'b1, 3'b010, DW'('h22)); push(3'b010, DW'('h22));
    cyc();
    chk("bp_ready_after_b", 128'(in_ready), 128'(0));
    drive(1'b1, 3'b011, DW'('h33));
    cyc(); cyc();
    chk("bp_hold_ready", 128'(in_ready), 128'(0));
    chk("bp_hold_data",  128'(out_data), 128'('h11));
    out_ready = 1'b1;
    cyc();
    chk("bp_ready_reopen", 128'(in_ready), 128'(1));
    chk("bp_main_b",       128'(out_data), 128'('h22));
    push(3'b011, DW'('h33));
    cyc();
    drive(1'b0, '0, '0);
    cyc(); cyc();
    chk("bp_all_delivered", 128'(sb_q.size()), 128'(0));

    // Flush while FULL with a beat presented upstream.
    out_ready = 1'b0;
    drive(1'b1, 3'b110, DW'('h55));
    cyc();
    drive(1'b1, 3'b110, DW'('h66));
    cyc();
    chk("fl_full", 128'(in_ready), 128'(0));
    drive(1'b1, 3'b111, DW'('h44));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("fl_out_valid", 128'(out_valid), 128'(0));
    chk("fl_out_ctrl",  128'(out_ctrl),  128'(0));
    chk("fl_in_ready",  128'(in_ready),  128'(1));
    out_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("fl_no_output", 128'(out_valid), 128'(0));

    // Bubble control: single beat, then idle; data held on the bubble.
    drive(1'b1, 3'b111, DW'('h77)); push(3'b111, DW'('h77));
    cyc();
    drive(1'b0, '0, '0);
    chk("bub_valid_ctrl", 128'(out_ctrl), 128'(3'b111));
    cyc();
    chk("bub_out_valid", 128'(out_valid), 128'(0));
    chk("bub_out_ctrl",  128'(out_ctrl),  128'(0));
    chk("bub_data_held", 128'(out_data),  128'('h77));

    // Async reset mid-stream with main and skid full.
    out_ready = 1'b0;
    drive(1'b1, 3'b100, DW'('h88));
    cyc();
    drive(1'b1, 3'b100, DW'('h99));
    cyc();
    drive(1'b0, '0, '0);
    chk("ar_full", 128'(in_ready), 128'(0));
    #1 rst = 1'b1;
    #1;
    chk("ar_out_valid", 128'(out_valid), 128'(0));
    chk("ar_out_ctrl",  128'(out_ctrl),  128'(0));
    chk("ar_out_data",  128'(out_data),  128'(0));
    chk("ar_in_ready",  128'(in_ready),  128'(1));
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    cyc(); cyc();
    chk("ar_dropped", 128'(out_valid), 128'(0));

`ifdef PIPE_STAGE_STALL_CNT_EN
    out_ready = 1'b0;
    drive(1'b1, 3'b001, DW'('hAA));
    cyc();
    drive(1'b0, '0, '0);
    repeat (20) cyc();
    chk("sc_saturate", 128'(stall_cnt), 128'(15));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    chk("sc_after_flush", 128'(stall_cnt), 128'(15));
    #1 rst = 1'b1;
    #1;
    chk("sc_rst_clear", 128'(stall_cnt), 128'(0));
    cyc();
    rst = 1'b0;
    cyc();
`endif

    chk("sb_empty", 128'(sb_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
